// File: rtl/div_req_pkg.sv
// Shared types for the divider requester: FSM state encoding and response status codes.
package div_req_pkg;

    localparam int unsigned STATUS_W = 3;

    typedef logic [STATUS_W-1:0] status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    localparam status_t ST_OK      = 3'd0;
    localparam status_t ST_DVZ     = 3'd1;
    localparam status_t ST_OVF     = 3'd2;
    localparam status_t ST_NOFLAG  = 3'd3;
    localparam status_t ST_TIMEOUT = 3'd4;

    // Completion flag priority: divide-by-zero beats overflow beats a plain valid result.
    function automatic status_t classify(input logic dvz, input logic ovf, input logic valid);
        if (dvz) begin
            return ST_DVZ;
        end else if (ovf) begin
            return ST_OVF;
        end else if (valid) begin
            return ST_OK;
        end
        return ST_NOFLAG;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO holding {dividend, divisor} pairs; pushed data is readable the next cycle.
module div_req_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/div_requester.sv
// Host-side initiator for the sequential divider: queues jobs, pulses start, tracks busy,
// classifies completion flags and returns quotient plus status in request order.
module div_requester
    import div_req_pkg::*;
#(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             req_ready_o,
    output logic             start_o,
    output logic [WIDTH-1:0] div_a_o,
    output logic [WIDTH-1:0] div_b_o,
    input  logic             busy_i,
    input  logic             valid_i,
    input  logic             ovf_i,
    input  logic             dvz_i,
    input  logic [WIDTH-1:0] div_q_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_quot_o,
    output logic [2:0]       rsp_status_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   div_a_q, div_a_d;
    logic [WIDTH-1:0]   div_b_q, div_b_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_quot_q, rsp_quot_d;
    status_t            rsp_status_q, rsp_status_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Ready comes from the registered count only, so a full FIFO never accepts a push-through.
    assign req_ready_o = !rst_i && (fifo_count < CNT_W'(DEPTH));
    assign fifo_push   = req_valid_i && req_ready_o && !fifo_full;

    div_req_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i ({req_a_i, req_b_i}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            wd_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_quot_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            wd_q         <= wd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_quot_q   <= rsp_quot_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_d      = 1'b0;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        wd_d         = wd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_quot_d   = rsp_quot_q;
        rsp_status_d = rsp_status_q;
        fifo_pop     = 1'b0;

        case (state_q)
            // The busy gate also holds off a new job while an abandoned one is still running.
            S_IDLE: begin
                if (!fifo_empty && !busy_i) begin
                    fifo_pop           = 1'b1;
                    {div_a_d, div_b_d} = fifo_rd_data;
                    start_d            = 1'b1;
                    state_d            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                wd_d = wd_q + WD_W'(1);
                if ((state_q == S_WAIT_DONE) && !busy_i) begin
                    rsp_quot_d   = div_q_i;
                    rsp_status_d = classify(dvz_i, ovf_i, valid_i);
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    rsp_quot_d   = '0;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if ((state_q == S_WAIT_BUSY) && busy_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign start_o      = start_q;
    assign div_a_o      = div_a_q;
    assign div_b_o      = div_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_quot_o   = rsp_quot_q;
    assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_div_requester.sv
// Scoreboard bench for div_requester driving a cycle-accurate behavioural divider model.
module tb_div_requester;

    localparam int unsigned W      = 10;
    localparam int unsigned D      = 4;
    localparam int unsigned TO     = 64;
    localparam int          CALC_N = 4;

    localparam logic [2:0] E_OK = 3'd0, E_DVZ = 3'd1, E_OVF = 3'd2, E_NOFLAG = 3'd3, E_TMO = 3'd4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [2:0]   st;
    } exp_t;

    typedef enum int {M_IDLE, M_LOAD, M_CALC, M_RES} mst_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [W-1:0] req_a, req_b;
    logic         req_ready;
    logic         start;
    logic [W-1:0] div_a, div_b;
    logic         busy, valid, ovf, dvz;
    logic [W-1:0] div_q;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_quot;
    logic [2:0]   rsp_status;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_start  = 0;
    int   n_rsp    = 0;
    int   last_start_cyc = 0;
    int   rsp_rise_cyc   = 0;
    int   last_acc_cyc   = 0;
    logic rsp_valid_prev = 1'b0;
    int   stub_mode = 0;   // 0 model, 1 busy stuck low, 2 busy stuck high
    int   flag_mode = 0;   // 0 valid, 1 ovf only, 2 no flags, 3 all flags
    exp_t sb_q[$];
    exp_t mon_e;

    mst_t         m_st;
    int           m_n;
    logic [W-1:0] m_a, m_b;

    div_requester #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ready_o  (req_ready),
        .start_o      (start),
        .div_a_o      (div_a),
        .div_b_o      (div_b),
        .busy_i       (busy),
        .valid_i      (valid),
        .ovf_i        (ovf),
        .dvz_i        (dvz),
        .div_q_i      (div_q),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_quot_o   (rsp_quot),
        .rsp_status_o (rsp_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural divider: LOAD (busy, dvz raised early for b==0), CALC*, then RESULT with busy low.
    always @(posedge clk) begin
        if (rst) begin
            m_st <= M_IDLE; busy <= 1'b0; valid <= 1'b0; ovf <= 1'b0; dvz <= 1'b0;
            div_q <= '0; m_n <= 0; m_a <= '0; m_b <= '0;
        end else if (stub_mode == 1) begin
            m_st <= M_IDLE; busy <= 1'b0; valid <= 1'b0; ovf <= 1'b0; dvz <= 1'b0;
        end else if (stub_mode == 2) begin
            m_st <= M_IDLE; busy <= 1'b1; valid <= 1'b0; ovf <= 1'b0; dvz <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    busy <= 1'b0; valid <= 1'b0; ovf <= 1'b0; dvz <= 1'b0;
                    if (start) begin
                        m_st <= M_LOAD; busy <= 1'b1; m_a <= div_a; m_b <= div_b;
                        dvz  <= (div_b == '0);
                    end
                end
                M_LOAD: begin
                    if (m_b == '0) begin
                        m_st <= M_RES; busy <= 1'b0; dvz <= 1'b1; div_q <= '1;
                    end else begin
                        m_st <= M_CALC; m_n <= CALC_N; dvz <= 1'b0;
                    end
                end
                M_CALC: begin
                    if (m_n == 1) begin
                        m_st  <= M_RES; busy <= 1'b0; div_q <= m_a / m_b;
                        valid <= (flag_mode == 0) || (flag_mode == 3);
                        ovf   <= (flag_mode == 1) || (flag_mode == 3);
                        dvz   <= (flag_mode == 3);
                    end else begin
                        m_n <= m_n - 1;
                    end
                end
                default: begin
                    m_st <= M_IDLE; valid <= 1'b0; ovf <= 1'b0; dvz <= 1'b0;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (start) begin
                n_start++;
                last_start_cyc = cyc;
            end
            if (rsp_valid && !rsp_valid_prev) rsp_rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_quot", int'(rsp_quot), int'(mon_e.q));
                    check("rsp_status", int'(rsp_status), int'(mon_e.st));
                    n_rsp++;
                end
            end
        end
        rsp_valid_prev = rsp_valid;
    end

    // Offer one job; records the expected response only if it is accepted.
    task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                            input logic [2:0] st, input int max_wait, output bit acc);
        exp_t e;
        req_a = a; req_b = b; req_valid = 1'b1; acc = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (req_ready) begin
                e.q = eq; e.st = st;
                sb_q.push_back(e);
                acc = 1'b1;
                @(posedge clk); #1;
                last_acc_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check(name, sb_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, int'(start), 0);
        check({tag, "_div_a"}, int'(div_a), 0);
        check({tag, "_div_b"}, int'(div_b), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_quot"}, int'(rsp_quot), 0);
        check({tag, "_rsp_status"}, int'(rsp_status), 0);
        check({tag, "_req_ready"}, int'(req_ready), 0);
    endtask

    logic [W-1:0] fa [7] = '{10'd100, 10'd200, 10'd50, 10'd999, 10'd81, 10'd77, 10'd64};
    logic [W-1:0] fb [7] = '{10'd7,   10'd9,   10'd5,  10'd10,  10'd3,  10'd7,  10'd8};
    logic [W-1:0] fq [7] = '{10'd14,  10'd22,  10'd10, 10'd99,  10'd27, 10'd11, 10'd8};

    initial begin
        bit acc;
        int s0, r0, n_acc;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(req_ready), 1);
        @(posedge clk); #1;

        // Basic job: single start, quotient 14, status OK
        s0 = n_start; r0 = n_rsp;
        push_job(10'd100, 10'd7, 10'd14, E_OK, 10, acc);
        drain("drain_basic", 100);
        check("basic_starts", n_start - s0, 1);
        check("basic_rsps", n_rsp - r0, 1);

        // Divide by zero: start in cycle 2, response in cycle 5
        push_job(10'd5, 10'd0, 10'h3FF, E_DVZ, 10, acc);
        drain("drain_dvz", 100);
        check("dvz_start_cycle", last_start_cyc - last_acc_cyc, 1);
        check("dvz_rsp_cycle", rsp_rise_cyc - last_acc_cyc, 4);

        // Flag classification
        flag_mode = 1;
        push_job(10'd300, 10'd2, 10'd150, E_OVF, 10, acc);
        drain("drain_ovf", 100);
        flag_mode = 2;
        push_job(10'd9, 10'd3, 10'd3, E_NOFLAG, 10, acc);
        drain("drain_noflag", 100);
        flag_mode = 3;
        push_job(10'd40, 10'd4, 10'd10, E_DVZ, 10, acc);
        drain("drain_prio", 100);
        flag_mode = 0;

        // Back-pressure: DEPTH+1 accepted while the host stalls responses
        rsp_ready = 1'b0; n_acc = 0; r0 = n_rsp;
        for (int i = 0; i < D + 3; i++) begin
            push_job(fa[i], fb[i], fq[i], E_OK, 20, acc);
            if (acc) n_acc++;
        end
        @(negedge clk);
        check("fifo_accepted", n_acc, D + 1);
        check("fifo_full_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain("drain_fifo", 600);
        check("fifo_rsps", n_rsp - r0, D + 1);

        // Divider never raises busy: abandoned after TIMEOUT cycles
        stub_mode = 1; s0 = n_start;
        push_job(10'd10, 10'd2, 10'd0, E_TMO, 10, acc);
        drain("drain_timeout", 300);
        check("timeout_starts", n_start - s0, 1);
        check("timeout_latency", rsp_rise_cyc - last_start_cyc, TO + 1);

        // Divider still busy: next job must wait for busy to drop
        stub_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        s0 = n_start;
        push_job(10'd60, 10'd6, 10'd10, E_OK, 10, acc);
        repeat (20) begin @(posedge clk); #1; end
        check("busy_gate_no_start", n_start - s0, 0);
        stub_mode = 0;
        drain("drain_gate", 100);
        check("busy_gate_start", n_start - s0, 1);

        // Reset while waiting for completion: result discarded
        r0 = n_rsp;
        push_job(10'd500, 10'd5, 10'd100, E_OK, 10, acc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check("mid_busy_seen", int'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", int'(req_ready), 1);
        repeat (20) begin @(posedge clk); #1; end
        check("midreset_no_rsp", n_rsp - r0, 0);
        push_job(10'd81, 10'd3, 10'd27, E_OK, 10, acc);
        drain("drain_recover", 100);
        check("recover_rsp", n_rsp - r0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/div_requester.md
# div_requester

Host-side initiator for the sequential divider's start/busy handshake. The block queues operand pairs from a host, issues one `start` pulse per job, and tracks the divider's `busy` until the job completes. It then classifies the completion flags (`valid`/`ovf`/`dvz`) and returns quotient plus status to the host in request order. It sits between the host bus and the divider top, driving the divider's operand inputs and `start` and consuming its `busy`, flags and quotient.

## Interface
- `WIDTH`, 10: operand/quotient width in bits
- `DEPTH`, 4: request FIFO entries (power of 2, ≥2)
- `TIMEOUT`, 64: max cycles from `start` to completion before a job is abandoned

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  host offers a job
- `req_a`, `req_b`  in  WIDTH  dividend, divisor
- `req_ready`  out  1  FIFO not full; job accepted when `req_valid & req_ready`
- `start`  out  1  one-cycle job pulse to divider
- `div_a`, `div_b`  out  WIDTH  operands to divider, held for whole job
- `busy`, `valid`, `ovf`, `dvz`  in  1 each  divider status outputs
- `div_q`  in  WIDTH  divider quotient
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  host accepts response
- `rsp_quot`  out  WIDTH  captured quotient
- `rsp_status`  out  3  0 OK, 1 DVZ, 2 OVF, 3 NOFLAG, 4 TIMEOUT

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if FIFO non-empty and `busy`=0, pop head into `div_a`/`div_b` and go to ISSUE. Otherwise stay.
- ISSUE: `start`=1 for exactly this cycle. Clear watchdog. Go to WAIT_BUSY.
- WAIT_BUSY: when `busy`=1, go to WAIT_DONE.
- WAIT_DONE: `busy`=0 marks the completion cycle. In that cycle, capture `div_q` and set status by priority: `dvz`→DVZ, else `ovf`→OVF, else `valid`→OK, else NOFLAG. Go to RESP.
- `dvz` asserted while `busy`=1 (divider load phase) is ignored. Flags are sampled only in the completion cycle.
- Watchdog counts every cycle spent in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT: `rsp_quot`=0, status TIMEOUT, go to RESP.
- RESP: `rsp_valid`=1 with `rsp_quot`/`rsp_status` stable until `rsp_ready`. The handshake cycle returns to IDLE.
- After a TIMEOUT, the IDLE `busy`=0 gate blocks the next `start` until the abandoned divider job has finished.
- FIFO: push when `req_valid & req_ready`. `req_ready` = count<DEPTH from registered count (no same-cycle push-through when full). Pushed data is poppable the following cycle. Simultaneous push and pop when not full: count unchanged.
- Responses leave in request order. Quotient is passed through unmodified.

## Timing
- Reset values: `start`=0, `div_a`=`div_b`=0, `rsp_valid`=0, `rsp_quot`=0, `rsp_status`=0, FSM=IDLE, FIFO empty, watchdog=0.
- `req_ready`=0 while `rst`=1, and 1 in the first cycle after release.
- Job latency, host push at edge E0 into an empty FIFO with divider idle:
  - cycle 1: IDLE pops.
  - cycle 2: `start`=1.
  - cycle 3: divider busy, WAIT_BUSY.
  - DVZ job: completion in cycle 4, `rsp_valid` in cycle 5.
  - General case: `rsp_valid` is asserted the cycle after `busy` falls.
- Back-to-back jobs: the next `start` comes no earlier than 2 cycles after the previous `rsp_valid` handshake (RESP→IDLE→ISSUE).
- Reset mid-job: all state cleared on that edge. The in-flight result is discarded and the FIFO contents are lost. The divider shares `rst`.
- `rsp_ready` held 1 during RESP: one-cycle `rsp_valid`.

## Structure
- Package `div_req_pkg`: state enum and status code constants (ST_OK, ST_DVZ, ST_OVF, ST_NOFLAG, ST_TIMEOUT).
- One sub-module, `div_req_fifo`: synchronous FIFO, parameters WIDTH×2 data and DEPTH, with push/pop/full/empty/count.
- FSM, watchdog and response registers live in `div_requester`.

## Test plan
All scenarios use a cycle-accurate behavioural divider model with IDLE→LOAD→CALC*→RESULT sequencing.
- Push a=100, b=7 → one `start` pulse, `rsp_quot`=14, `rsp_status`=0, single response.
- Push a=5, b=0 into empty FIFO at E0 → `start` in cycle 2, `rsp_valid` in cycle 5, status 1. The load-phase `dvz` does not end the job early.
- Model forces `ovf` at completion with `valid`=0 → status 2; with no flag at all → status 3.
- `rsp_ready`=0 with DEPTH+3 back-to-back pushes → exactly DEPTH+1 accepted, then `req_ready`=0. Release `rsp_ready` → responses come out in push order, with correct quotients.
- Stub holds `busy`=0 forever → status 4 after TIMEOUT cycles. Next, stub holds `busy`=1 across the next job → no `start` issued until `busy`=0.
- Assert `rst` in WAIT_DONE → next cycle all outputs at reset values. No response for the in-flight job. `req_ready`=1 after release.
